// File: rtl/tdm_demux_pkg.sv
// ---------------------------------------------------------------------------
// tdm_demux_pkg
// Shared types and constants for the 1:N TDM demultiplexer slice.
//   state_t      : alignment state (HUNT = waiting for sof, RECV = aligned)
//   slot_w()     : width of the slot index for a given channel count
//   FRAME_CNT_W  : width of the optional completed-frame counter
// Optional feature macro: TDM_DEMUX_FRAME_CNT_EN (adds frame_cnt output).
// ---------------------------------------------------------------------------
package tdm_demux_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_t;

    localparam int FRAME_CNT_W = 16;

`ifdef TDM_DEMUX_FRAME_CNT_EN
    localparam bit HAS_FRAME_CNT = 1'b1;
`else
    localparam bit HAS_FRAME_CNT = 1'b0;
`endif

    // A single-slot frame still needs one index bit to keep ports legal.
    function automatic int slot_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/tdm_demux_1to4_if.sv
// ---------------------------------------------------------------------------
// tdm_demux_1to4_if
// Bundles the TDM lane input and the parallel frame output of the demux.
//   din/din_valid/sof : incoming slot sample, its qualifier, start of frame
//   q/q_valid         : assembled frame and its one-cycle publish pulse
//   slot              : slot index expected for the next accepted sample
//   frame_err         : one-cycle framing violation pulse
//   frame_cnt         : completed-frame count (only with TDM_DEMUX_FRAME_CNT_EN)
// Modports: master = lane source / frame consumer, slave = the demux.
// ---------------------------------------------------------------------------
interface tdm_demux_1to4_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 1
);
    import tdm_demux_pkg::*;

    localparam int SLOT_W = slot_w(NUM_CH);

    logic [DATA_W-1:0]        din;
    logic                     din_valid;
    logic                     sof;
    logic [NUM_CH*DATA_W-1:0] q;
    logic                     q_valid;
    logic [SLOT_W-1:0]        slot;
    logic                     frame_err;
`ifdef TDM_DEMUX_FRAME_CNT_EN
    logic [FRAME_CNT_W-1:0]   frame_cnt;
`endif

    modport master (
        output din, din_valid, sof,
        input  q, q_valid, slot, frame_err
`ifdef TDM_DEMUX_FRAME_CNT_EN
        , input frame_cnt
`endif
    );

    modport slave (
        input  din, din_valid, sof,
        output q, q_valid, slot, frame_err
`ifdef TDM_DEMUX_FRAME_CNT_EN
        , output frame_cnt
`endif
    );

endinterface

// File: rtl/tdm_slot_ctr.sv
// ---------------------------------------------------------------------------
// tdm_slot_ctr
// Modulo-NUM_CH slot counter.
//   clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//   clr        : synchronous clear to 0 (highest priority)
//   load1      : synchronous load of 1 (sof restart: slot 0 consumed)
//   en         : advance by one, wrapping NUM_CH-1 -> 0
//   cnt        : current slot index
// ---------------------------------------------------------------------------
module tdm_slot_ctr #(
    parameter int NUM_CH = 4,
    parameter int SLOT_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              load1,
    input  logic              clr,
    output logic [SLOT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load1) begin
            cnt <= SLOT_W'(1);
        end else if (en) begin
            cnt <= (cnt == SLOT_W'(NUM_CH - 1)) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tdm_demux_1to4.sv
// ---------------------------------------------------------------------------
// tdm_demux_1to4
// Rebuilds a parallel NUM_CH-channel word from a TDM lane stream whose slot
// select runs 0,1,..,NUM_CH-1,0,... Samples land in per-slot capture
// registers; the sample of the last slot completes the frame, which is
// loaded into q with a one-cycle q_valid pulse. Framing violations raise a
// one-cycle frame_err and either resync on an early sof or fall back to HUNT.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : tdm_demux_1to4_if.slave (din, din_valid, sof, q, q_valid,
//                slot, frame_err, and frame_cnt when enabled)
// Optional feature macro: TDM_DEMUX_FRAME_CNT_EN adds a 16-bit wrapping
// frame_cnt that increments on every edge that loads q.
// ---------------------------------------------------------------------------
module tdm_demux_1to4
    import tdm_demux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    tdm_demux_1to4_if.slave   bus
);

    localparam int SLOT_W = slot_w(NUM_CH);

    state_t                   state;
    state_t                   state_next;
    logic [SLOT_W-1:0]        slot;
    logic                     ctr_en;
    logic                     ctr_load1;
    logic                     ctr_clr;
    logic                     cap_we;
    logic [SLOT_W-1:0]        cap_sel;
    logic                     frame_done;
    logic                     err;
    logic [NUM_CH*DATA_W-1:0] frame_word;

    logic [DATA_W-1:0]        cap_p0 [NUM_CH-1];
    logic [NUM_CH*DATA_W-1:0] q_p1;
    logic                     q_valid_p1;
    logic                     frame_err_p1;

    tdm_slot_ctr #(
        .NUM_CH (NUM_CH),
        .SLOT_W (SLOT_W)
    ) u_slot_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ctr_en),
        .load1 (ctr_load1),
        .clr   (ctr_clr),
        .cnt   (slot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HUNT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ctr_en     = 1'b0;
        ctr_load1  = 1'b0;
        ctr_clr    = 1'b0;
        cap_we     = 1'b0;
        cap_sel    = slot;
        frame_done = 1'b0;
        err        = 1'b0;

        if (bus.din_valid) begin
            unique case (state)
                HUNT: begin
                    // Unaligned samples are dropped silently until sof.
                    if (bus.sof) begin
                        cap_we     = 1'b1;
                        cap_sel    = '0;
                        ctr_load1  = 1'b1;
                        state_next = RECV;
                    end
                end
                RECV: begin
                    if (slot == '0) begin
                        if (bus.sof) begin
                            cap_we    = 1'b1;
                            cap_sel   = '0;
                            ctr_load1 = 1'b1;
                        end else begin
                            err        = 1'b1;
                            ctr_clr    = 1'b1;
                            state_next = HUNT;
                        end
                    end else if (bus.sof) begin
                        // Early sof: restart the frame right here; stale
                        // captures are overwritten before they can publish.
                        err       = 1'b1;
                        cap_we    = 1'b1;
                        cap_sel   = '0;
                        ctr_load1 = 1'b1;
                    end else if (slot == SLOT_W'(NUM_CH - 1)) begin
                        frame_done = 1'b1;
                        ctr_en     = 1'b1;
                    end else begin
                        cap_we = 1'b1;
                        ctr_en = 1'b1;
                    end
                end
                default: state_next = HUNT;
            endcase
        end
    end

    // The last slot is never stored: it goes straight from din into q.
    always_comb begin
        frame_word = '0;
        for (int k = 0; k < NUM_CH - 1; k++) begin
            frame_word[k*DATA_W +: DATA_W] = cap_p0[k];
        end
        frame_word[(NUM_CH-1)*DATA_W +: DATA_W] = bus.din;
    end

    // ---- stage p0: per-slot capture ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH - 1; k++) begin
                cap_p0[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CH - 1; k++) begin
                if (cap_we && (cap_sel == SLOT_W'(k))) begin
                    cap_p0[k] <= bus.din;
                end
            end
        end
    end

    // ---- stage p1: frame publish and error pulse ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_p1         <= '0;
            q_valid_p1   <= 1'b0;
            frame_err_p1 <= 1'b0;
        end else begin
            q_valid_p1   <= frame_done;
            frame_err_p1 <= err;
            if (frame_done) begin
                q_p1 <= frame_word;
            end
        end
    end

`ifdef TDM_DEMUX_FRAME_CNT_EN
    logic [FRAME_CNT_W-1:0] frame_cnt_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_p1 <= '0;
        end else if (frame_done) begin
            frame_cnt_p1 <= frame_cnt_p1 + 1'b1;
        end
    end

    assign bus.frame_cnt = frame_cnt_p1;
`endif

    assign bus.q         = q_p1;
    assign bus.q_valid   = q_valid_p1;
    assign bus.frame_err = frame_err_p1;
    assign bus.slot      = slot;

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// ---------------------------------------------------------------------------
// tb_tdm_demux_1to4
// Directed bench for tdm_demux_1to4 (NUM_CH=4, DATA_W=1). A frame-level
// model (queue of samples in the current frame) predicts q, q_valid,
// frame_err, slot (and frame_cnt when TDM_DEMUX_FRAME_CNT_EN is defined);
// a compare process checks them every falling edge, and the main sequence
// adds literal expectations at key points.
// ---------------------------------------------------------------------------
module tb_tdm_demux_1to4;
    import tdm_demux_pkg::*;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 1;

    logic clk;
    logic rst_n;
    bit   chk_en;
    int   vectors;
    int   miscompares;

    tdm_demux_1to4_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

    tdm_demux_1to4 #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- frame-level model ----------------
    bit                       aligned;
    logic [DATA_W-1:0]        part [$];
    logic [NUM_CH*DATA_W-1:0] m_q   = '0;
    logic                     m_qv  = 1'b0;
    logic                     m_err = 1'b0;
    int                       m_cnt = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aligned = 1'b0;
            part.delete();
            m_q   = '0;
            m_qv  = 1'b0;
            m_err = 1'b0;
            m_cnt = 0;
        end else begin
            m_qv  = 1'b0;
            m_err = 1'b0;
            if (bus.din_valid) begin
                if (bus.sof) begin
                    if (aligned && part.size() != 0) m_err = 1'b1;
                    part.delete();
                    part.push_back(bus.din);
                    aligned = 1'b1;
                end else if (aligned) begin
                    if (part.size() == 0) begin
                        m_err   = 1'b1;
                        aligned = 1'b0;
                    end else begin
                        part.push_back(bus.din);
                        if (part.size() == NUM_CH) begin
                            for (int k = 0; k < NUM_CH; k++)
                                m_q[k*DATA_W +: DATA_W] = part[k];
                            m_qv  = 1'b1;
                            m_cnt = (m_cnt + 1) % 65536;
                            part.delete();
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_q",         32'(bus.q),         32'(m_q));
            chk("model_q_valid",   32'(bus.q_valid),   32'(m_qv));
            chk("model_frame_err", 32'(bus.frame_err), 32'(m_err));
            chk("model_slot",      32'(bus.slot),      32'(part.size()));
`ifdef TDM_DEMUX_FRAME_CNT_EN
            chk("model_frame_cnt", 32'(bus.frame_cnt), 32'(m_cnt));
`endif
        end
    end

    // ---------------- stimulus ----------------
    // Drive one cycle's inputs, then return just after the following
    // falling edge so the outputs show the effect of that cycle's edge.
    task automatic step(input logic v, input logic s, input logic d);
        bus.din       = d;
        bus.din_valid = v;
        bus.sof       = s;
        @(negedge clk);
        #1;
    endtask

    // q bit k is channel k, so channel 0 is sent first.
    task automatic send_frame(input logic [3:0] w);
        for (int k = 0; k < NUM_CH; k++) step(1'b1, k == 0, w[k]);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        chk_en      = 1'b0;
        rst_n       = 1'b0;
        bus.din       = '0;
        bus.din_valid = 1'b0;
        bus.sof       = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_q",         32'(bus.q),         32'h0);
        chk("rst_q_valid",   32'(bus.q_valid),   32'h0);
        chk("rst_frame_err", 32'(bus.frame_err), 32'h0);
        chk("rst_slot",      32'(bus.slot),      32'h0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        step(1'b0, 1'b0, 1'b0);

        // Aligned frame 1101
        send_frame(4'b1101);
        chk("f1_q",       32'(bus.q),       32'hD);
        chk("f1_q_valid", 32'(bus.q_valid), 32'h1);
        chk("f1_slot",    32'(bus.slot),    32'h0);
        step(1'b0, 1'b0, 1'b0);
        chk("f1_pulse_end", 32'(bus.q_valid), 32'h0);
        chk("f1_q_hold",    32'(bus.q),       32'hD);

        // Three back-to-back frames
        send_frame(4'b1101);
        chk("b2b0_q", 32'(bus.q), 32'hD);
        send_frame(4'b0010);
        chk("b2b1_q", 32'(bus.q), 32'h2);
        chk("b2b1_v", 32'(bus.q_valid), 32'h1);
        send_frame(4'b1111);
        chk("b2b2_q", 32'(bus.q), 32'hF);

        // Frame 1010 with a two-cycle gap after slot 1
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("gap_slot0", 32'(bus.slot), 32'h2);
        step(1'b0, 1'b1, 1'b0);
        chk("gap_slot1", 32'(bus.slot), 32'h2);
        chk("gap_no_v",  32'(bus.q_valid), 32'h0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        chk("gap_q", 32'(bus.q), 32'hA);
        chk("gap_v", 32'(bus.q_valid), 32'h1);

        // Early sof at slot 2 resyncs; next frame is 1001
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        chk("early_err",  32'(bus.frame_err), 32'h1);
        chk("early_slot", 32'(bus.slot),      32'h1);
        chk("early_qold", 32'(bus.q),         32'hA);
        step(1'b1, 1'b0, 1'b0);
        chk("early_err_end", 32'(bus.frame_err), 32'h0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        chk("early_q", 32'(bus.q), 32'h9);
        chk("early_v", 32'(bus.q_valid), 32'h1);

        // Missing sof at slot 0 drops to HUNT; samples ignored until sof
        step(1'b1, 1'b0, 1'b1);
        chk("miss_err",  32'(bus.frame_err), 32'h1);
        chk("miss_slot", 32'(bus.slot),      32'h0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        chk("hunt_err",  32'(bus.frame_err), 32'h0);
        chk("hunt_slot", 32'(bus.slot),      32'h0);
        chk("hunt_q",    32'(bus.q),         32'h9);
        send_frame(4'b0110);
        chk("miss_q", 32'(bus.q), 32'h6);
        chk("miss_v", 32'(bus.q_valid), 32'h1);

        // Asynchronous reset mid-frame (after slot 2 accepted)
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk("pre_rst_slot", 32'(bus.slot), 32'h3);
        bus.din_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_q",    32'(bus.q),    32'h0);
        chk("arst_slot", 32'(bus.slot), 32'h0);
        chk("arst_v",    32'(bus.q_valid), 32'h0);
`ifdef TDM_DEMUX_FRAME_CNT_EN
        chk("arst_cnt",  32'(bus.frame_cnt), 32'h0);
`endif
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        send_frame(4'b1101);
        chk("post_rst_q1", 32'(bus.q), 32'hD);
`ifdef TDM_DEMUX_FRAME_CNT_EN
        chk("cnt1", 32'(bus.frame_cnt), 32'h1);
`endif
        send_frame(4'b0110);
        chk("post_rst_q2", 32'(bus.q), 32'h6);
`ifdef TDM_DEMUX_FRAME_CNT_EN
        chk("cnt2", 32'(bus.frame_cnt), 32'h2);
`endif
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
